// File: rtl/fmap_pkg.sv
// Shared types and constants for the feature-map read path.
// Beat layout and FSM encoding used by fmap_reader and its bench.
package fmap_pkg;

  localparam int FMAP_ADDR_W = 8;
  localparam int FMAP_DATA_W = 16;
  localparam int FMAP_DEPTH  = 196;
  localparam int FMAP_BANKS  = 16;

  typedef logic [FMAP_DATA_W-1:0] fmap_word_t;

  typedef struct packed {
    logic [FMAP_BANKS*FMAP_DATA_W-1:0] data;
    logic [FMAP_ADDR_W-1:0]            idx;
    logic                              last;
  } fmap_beat_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fmap_state_e;

endpackage

// File: rtl/fmap_skid_fifo.sv
// Two-entry synchronous skid FIFO holding captured SRAM beats.
// Head is presented combinationally and stays put until popped.
module fmap_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop & (count != 2'd0);
  assign do_push = push & ((count != 2'd2) | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fmap_reader.sv
// Scans all bank addresses once per start and streams 16-lane words
// downstream, hiding the 1-cycle SRAM latency behind a skid FIFO.
module fmap_reader
  import fmap_pkg::*;
#(
  parameter int ADDR_WIDTH = FMAP_ADDR_W,
  parameter int DATA_WIDTH = FMAP_DATA_W,
  parameter int DEPTH      = FMAP_DEPTH,
  parameter int NUM_BANKS  = FMAP_BANKS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [ADDR_WIDTH-1:0]           rd_addr,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]           out_idx,
  output logic                            out_last
);

  localparam int DW = NUM_BANKS * DATA_WIDTH;
  localparam int BW = DW + ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef struct packed {
    logic [DW-1:0]         data;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  last;
  } beat_t;

  fmap_state_e           state;
  fmap_state_e           state_nxt;
  logic                  issue;
  logic                  pop;
  logic                  fin;
  logic                  inflight;
  logic [ADDR_WIDTH:0]   issue_cnt;
  logic [ADDR_WIDTH-1:0] tag;
  logic [1:0]            fifo_count;
  logic [2:0]            occ;
  beat_t                 cap;
  beat_t                 head;

  assign out_valid = fifo_count != 2'd0;
  assign pop       = out_valid & out_ready;
  assign fin       = pop & head.last;
  // Occupancy the FIFO will see once the in-flight read lands.
  assign occ = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (fin)   state_nxt = ST_IDLE;
      default:            state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    issue = 1'b0;
    unique case (state)
      ST_RUN: begin
        busy  = 1'b1;
        issue = (issue_cnt < DEPTH_CNT) && (occ < 3'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_addr   <= '0;
      issue_cnt <= '0;
      inflight  <= 1'b0;
      tag       <= '0;
      done      <= 1'b0;
    end else begin
      done     <= (state == ST_RUN) & fin;
      inflight <= issue;
      if (issue) begin
        tag       <= rd_addr;
        issue_cnt <= issue_cnt + 1'b1;
        if (rd_addr != LAST_ADDR)
          rd_addr <= rd_addr + 1'b1;
      end
      if (state_nxt == ST_IDLE) begin
        rd_addr   <= '0;
        issue_cnt <= '0;
      end
    end
  end

  assign cap.data = rd_data;
  assign cap.idx  = tag;
  assign cap.last = tag == LAST_ADDR;

  fmap_skid_fifo #(
    .WIDTH(BW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight),
    .push_data(cap),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count)
  );

  assign out_data = head.data;
  assign out_idx  = head.idx;
  assign out_last = head.last;

endmodule

// File: tb/tb_fmap_reader.sv
// Scoreboard bench for fmap_reader: random backpressure, stalls,
// overlapping starts, mid-scan reset and a DEPTH=1 instance.
module tb_fmap_reader;
  import fmap_pkg::*;

  localparam int D  = FMAP_DEPTH;
  localparam int DW = FMAP_BANKS * FMAP_DATA_W;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic [7:0]    rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [7:0]    out_idx;
  logic          out_last;

  logic          start1;
  logic          busy1;
  logic          done1;
  logic [7:0]    rd_addr1;
  logic [DW-1:0] rd_data1;
  logic          valid1;
  logic          ready1;
  logic [DW-1:0] data1;
  logic [7:0]    idx1;
  logic          last1;

  fmap_reader u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
  );

  fmap_reader #(.DEPTH(1)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1),
    .done(done1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .out_valid(valid1), .out_ready(ready1),
    .out_data(data1), .out_idx(idx1), .out_last(last1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Lane k at address a holds k*256 + a.
  function automatic logic [DW-1:0] model_data(int a);
    logic [DW-1:0] d;
    for (int k = 0; k < FMAP_BANKS; k++)
      d[k*16 +: 16] = 16'(k * 256 + a);
    return d;
  endfunction

  always @(posedge clk) begin
    rd_data  <= model_data(int'(rd_addr));
    rd_data1 <= model_data(int'(rd_addr1));
  end

  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;
  bit mode_rand = 0;
  fmap_beat_t exp_q[$];

  task automatic check(string name, logic [271:0] act, logic [271:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (mode_rand) out_ready = 1'($urandom_range(0, 1));
  endtask

  int start_cyc;

  task automatic start_scan();
    start = 1'b1;
    step();
    start = 1'b0;
    start_cyc = cyc;
    for (int a = 0; a < D; a++)
      exp_q.push_back('{data: model_data(a), idx: 8'(a), last: (a == D - 1)});
  endtask

  task automatic wait_idx(int idx);
    bit found = 0;
    for (int i = 0; i < 2000; i++) begin
      if (out_valid && int'(out_idx) == idx) begin
        found = 1;
        break;
      end
      step();
    end
    check($sformatf("reach_idx_%0d", idx), found, 1);
  endtask

  task automatic wait_done();
    bit found = 0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        found = 1;
        break;
      end
      step();
    end
    check("done_seen", found, 1);
  endtask

  // Monitor: scoreboard pop, done pulse timing and head stability.
  bit            expect_done = 0;
  bit            hold_v = 0;
  logic [7:0]    hold_idx;
  logic [DW-1:0] hold_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      expect_done = 0;
      hold_v = 0;
    end else begin
      if (expect_done)
        check("done_after_last", {done, busy}, 2'b10);
      else if (done)
        check("spurious_done", done, 0);
      if (hold_v)
        check("stall_hold", {out_valid, out_idx, out_data},
              {1'b1, hold_idx, hold_data});
      expect_done = 0;
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", out_idx, 9'h100);
        end else begin
          fmap_beat_t e;
          e = exp_q.pop_front();
          check($sformatf("beat_%0d", e.idx), {out_data, out_idx, out_last},
                {e.data, e.idx, e.last});
        end
        if (out_idx == 8'd37)
          check("lane5_idx37", out_data[5*16 +: 16], 16'h0525);
        if (out_last) expect_done = 1;
      end
      hold_v    = out_valid && !out_ready;
      hold_idx  = out_idx;
      hold_data = out_data;
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    start1 = 1'b0;
    ready1 = 1'b0;
    repeat (2) step();
    check("rst_state", {busy, done, out_valid, out_last, rd_addr, out_idx},
          '0);
    check("rst_data", out_data, '0);
    rst_n = 1'b1;
    step();

    // DEPTH=1 instance
    ready1 = 1'b1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    check("d1_no_valid_yet", valid1, 0);
    step();
    check("d1_beat", {valid1, idx1, last1, data1},
          {1'b1, 8'd0, 1'b1, model_data(0)});
    step();
    check("d1_done", {done1, busy1, valid1}, 3'b100);
    step();
    check("d1_done_once", done1, 0);

    // Full-rate scan
    out_ready = 1'b1;
    start_scan();
    check("busy_on_start", {busy, out_valid}, 2'b10);
    step();
    check("lat_e1", out_valid, 0);
    step();
    check("lat_e2", {out_valid, out_idx}, {1'b1, 8'd0});
    wait_done();
    check("done_cycle", cyc - start_cyc, D + 2);
    check("busy_low_at_done", busy, 0);

    // Long stall at idx 50
    step();
    start_scan();
    wait_idx(50);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_idx", out_idx, 8'd50);
      check("stall_rd_addr_bound", rd_addr <= 8'd52, 1);
    end
    out_ready = 1'b1;
    wait_done();

    // Random backpressure
    step();
    hs_cnt = 0;
    mode_rand = 1;
    start_scan();
    wait_done();
    mode_rand = 0;
    out_ready = 1'b1;
    step();
    check("rand_handshakes", hs_cnt, D);

    // Overlapping starts
    start_scan();
    wait_idx(100);
    start = 1'b1;
    step();
    start = 1'b0;
    check("ignored_start_busy", busy, 1);
    wait_done();
    start_scan();
    check("restart_busy", busy, 1);
    wait_done();

    // Reset mid-scan
    step();
    start_scan();
    wait_idx(80);
    out_ready = 1'b0;
    rst_n = 1'b0;
    step();
    check("mid_rst", {out_valid, busy, rd_addr}, '0);
    exp_q.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    start_scan();
    wait_done();
    step();
    step();
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
